// File: rtl/console_escape_mux_pkg.sv
// Shared constants for the console mux: ASCII digit base, default escape
// byte and the escape FSM state encodings (also used by the TX-side mux).
package console_escape_mux_pkg;

    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ESC_CHAR_DEFAULT = 8'h01;

    // Escape scanner states
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_ESC    = 1'b1;

endpackage

// File: rtl/console_escape_mux_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through buffer. The head byte and
// the valid flag are held in registers so downstream logic sees clean
// flop outputs; storage is a plain array written at the tail pointer.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          pop_ok;
    logic          push_ok;

    // A pop frees a slot on the same edge, so a full buffer still accepts a push then.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        valid_d  = (count_d != '0);
        head_d   = head_q;
        if (pop_ok) begin
            if (count_q > CW'(1)) begin
                head_d = mem[rd_ptr_q + 1'b1];
            end else if (push_ok) begin
                head_d = din;
            end
        end else if ((count_q == '0) && push_ok) begin
            head_d = din;
        end
    end

    // Storage array: written at the tail, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign dout  = head_q;
    assign empty = !valid_q;
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/console_escape_mux.sv
// console_escape_mux: scans bytes from uart_rx for ESC_CHAR + digit to
// switch the active console channel; all other bytes are forwarded through
// a FWFT buffer with a valid/ready handshake.
module console_escape_mux
    import console_escape_mux_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter int         CH_W        = 2,
    parameter logic [7:0] ESC_CHAR    = ESC_CHAR_DEFAULT,
    parameter int         ESC_TIMEOUT = 100000,
    parameter int         FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_ready,
    input  logic [7:0]      rx_data,
    output logic            out_valid,
    output logic [7:0]      out_data,
    input  logic            out_ready,
    output logic [CH_W-1:0] sel_ch,
    output logic            sel_changed,
    output logic            overflow
);

    localparam int TO_W = $clog2(ESC_TIMEOUT + 1);

    logic            rx_ready_q;
    logic            accept;
    logic [0:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [CH_W-1:0] sel_ch_q, sel_ch_d;
    logic            sel_changed_q, sel_changed_d;
    logic            overflow_q, overflow_d;
    logic            push_req;
    logic [7:0]      push_data;
    logic [7:0]      digit_off;
    logic            is_digit;
    logic            timeout_hit;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;

    assign accept      = rx_ready && !rx_ready_q;
    assign digit_off   = rx_data - ASCII_0;
    assign is_digit    = (rx_data >= ASCII_0) && (digit_off < 8'(NUM_CH));
    assign timeout_hit = (state_q == ST_ESC) && (to_cnt_q == TO_W'(ESC_TIMEOUT - 1));
    assign fifo_pop    = !fifo_empty && out_ready;

    // Escape FSM: decides what (if anything) to push and when the channel changes.
    always_comb begin
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        sel_ch_d      = sel_ch_q;
        sel_changed_d = 1'b0;
        push_req      = 1'b0;
        push_data     = rx_data;
        if (state_q == ST_NORMAL) begin
            to_cnt_d = '0;
            if (accept) begin
                if (rx_data == ESC_CHAR) begin
                    state_d = ST_ESC;
                end else begin
                    push_req = 1'b1;
                end
            end
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (accept) begin
                // A real byte wins over a timeout firing on the same edge.
                state_d  = ST_NORMAL;
                to_cnt_d = '0;
                if (is_digit) begin
                    sel_ch_d      = digit_off[CH_W-1:0];
                    sel_changed_d = 1'b1;
                end else begin
                    // Covers the doubled ESC too: the byte itself is the literal.
                    push_req = 1'b1;
                end
            end else if (timeout_hit) begin
                state_d   = ST_NORMAL;
                to_cnt_d  = '0;
                push_req  = 1'b1;
                push_data = ESC_CHAR;
            end
        end
        overflow_d = overflow_q || (push_req && fifo_full && !fifo_pop);
    end

    // Control state; rx_ready_q resets high so a flag held through reset is not a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q    <= 1'b1;
            state_q       <= ST_NORMAL;
            to_cnt_q      <= '0;
            sel_ch_q      <= '0;
            sel_changed_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            rx_ready_q    <= rx_ready;
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            sel_ch_q      <= sel_ch_d;
            sel_changed_q <= sel_changed_d;
            overflow_q    <= overflow_d;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .din   (push_data),
        .pop   (fifo_pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign sel_ch      = sel_ch_q;
    assign sel_changed = sel_changed_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_console_escape_mux.sv
// Scoreboard bench for console_escape_mux: stimulus pushes expected output
// bytes into a queue, a negedge monitor pops and compares every transfer.
module tb_console_escape_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] sel_ch;
    logic       sel_changed;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int sc_count = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    console_escape_mux #(
        .NUM_CH      (4),
        .CH_W        (2),
        .ESC_CHAR    (8'h01),
        .ESC_TIMEOUT (50),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .sel_ch      (sel_ch),
        .sel_changed (sel_changed),
        .overflow    (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s got=%0h", name, act);
        end
    endtask

    // Monitor: each negedge with valid&&ready is one transfer at the next posedge.
    always @(negedge clk) begin
        if (sel_changed) sc_count++;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_data unexpected got=%0h expected=none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    failures++;
                    $display("FAIL out_data got=%0h expected=%0h", out_data, e);
                end else begin
                    $display("ok   out_data got=%0h", out_data);
                end
            end
        end
    end

    // One-cycle rx_ready pulse; returns just after the accepting edge.
    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int sc0;
        // Reset state
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset sel_ch", sel_ch, 0);
        check("reset sel_changed", sel_changed, 0);
        check("reset overflow", overflow, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: plain data forwarded
        exp_q.push_back(8'h41); send(8'h41);
        exp_q.push_back(8'h42); send(8'h42);
        wait_drain("t1 drain");
        check("t1 sel_ch", sel_ch, 0);

        // 2: channel switch, then out-of-range digit forwarded
        sc0 = sc_count;
        send(8'h01); send(8'h32);
        repeat (4) @(posedge clk); #1;
        check("t2 sel_ch", sel_ch, 2);
        check("t2 sel_changed pulses", sc_count - sc0, 1);
        check("t2 no output", out_valid, 0);
        exp_q.push_back(8'h37);
        send(8'h01); send(8'h37);
        wait_drain("t2 drain");
        check("t2 sel_ch kept", sel_ch, 2);

        // 3: doubled ESC, then ESC timeout
        exp_q.push_back(8'h01);
        send(8'h01); send(8'h01);
        wait_drain("t3 esc-esc drain");
        exp_q.push_back(8'h01);
        send(8'h01);
        repeat (49) @(posedge clk); #1;
        check("t3 before timeout", out_valid, 0);
        @(posedge clk); #1;
        check("t3 timeout valid", out_valid, 1);
        wait_drain("t3 timeout drain");
        exp_q.push_back(8'h5a);
        send(8'h5a);
        wait_drain("t3 back in normal");

        // 4: overflow
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'h10 + 8'(i));
            send(8'h10 + 8'(i));
        end
        @(posedge clk); #1;
        check("t4 overflow", overflow, 1);
        check("t4 head", out_data, 8'h10);
        out_ready = 1'b1;
        wait_drain("t4 drain");
        check("t4 overflow sticky", overflow, 1);

        // 5: level-held flag and flag held across reset release
        exp_q.push_back(8'h55);
        @(posedge clk); #1;
        rx_ready = 1'b1; rx_data = 8'h55;
        repeat (5) @(posedge clk); #1;
        check("t5 held valid", out_valid, 0);
        wait_drain("t5 held one byte");
        rx_data = 8'h66;
        rst_n = 1'b0;
        #1;
        check("t5 rst overflow", overflow, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("t5 none at release", out_valid, 0);
        rx_ready = 1'b0;
        exp_q.push_back(8'h77);
        send(8'h77);
        wait_drain("t5 after release");

        // 6: reset mid-stream while in ESC with 3 bytes buffered
        send(8'h01); send(8'h31);
        @(posedge clk); #1;
        check("t6 sel_ch before", sel_ch, 1);
        out_ready = 1'b0;
        send(8'h21); send(8'h22); send(8'h23);
        send(8'h01);
        @(posedge clk); #1;
        check("t6 buffered valid", out_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6 rst out_valid", out_valid, 0);
        check("t6 rst sel_ch", sel_ch, 0);
        check("t6 rst overflow", overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(8'h33);
        send(8'h33);
        wait_drain("t6 33 as data");
        check("t6 sel_ch after", sel_ch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
